// File: rtl/decode_pipeline_unit_pkg.sv
// Shared types for the decode stage: instruction fields, control bundle, opcode map.
// Pure declarations; no logic.
package signals;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {DEST_RT = 2'd0, DEST_RD = 2'd1, DEST_R31 = 2'd2} dest_sel_e;
    typedef enum logic [1:0] {IMM_SIGN = 2'd0, IMM_ZERO = 2'd1, IMM_UPPER = 2'd2} imm_ext_e;
    typedef enum logic [1:0] {BR_NONE = 2'd0, BR_EQ = 2'd1, BR_NE = 2'd2} branch_e;
    typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_J = 2'd1, JMP_JR = 2'd2} jump_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_FUNCT = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] jaddr;
    } unpack_t;

    typedef struct packed {
        logic      write_reg;
        dest_sel_e dest_sel;
        logic      alu_src_imm;
        imm_ext_e  imm_ext;
        alu_op_e   alu_op;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        branch_e   branch;
        jump_e     jump;
        logic      link;
        logic      illegal;
    } control_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

endpackage

// File: rtl/decode_pipeline_unit_if.sv
// Fetch-to-decode bundle plus the decoded view handed to the rest of the stage.
// master drives stall/nullify/in_*, slave (the decode unit) drives out_*/unpack/ctl.
interface decode_pipeline_unit_if;
    import signals::*;

    logic        stall;
    logic        nullify;
    logic [31:0] in_pc;
    logic [31:0] in_pcadd4;
    logic [31:0] in_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pcadd4;
    logic [31:0] out_instruction;
    unpack_t     unpack;
    control_t    ctl;

    modport master (
        output stall, nullify, in_pc, in_pcadd4, in_instruction,
        input  out_pc, out_pcadd4, out_instruction, unpack, ctl
    );

    modport slave (
        input  stall, nullify, in_pc, in_pcadd4, in_instruction,
        output out_pc, out_pcadd4, out_instruction, unpack, ctl
    );
endinterface

// File: rtl/decode_pipeline_unit_decoder.sv
// Main-opcode decoder: combinational, zero latency, no flow control.
// Unknown opcodes yield an all-zero bundle with only illegal set.
module opcode_decoder
    import signals::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output control_t   o_ctl
);
    always_comb begin
        o_ctl = '0;
        case (i_opcode)
            OP_SPECIAL: begin
                o_ctl.write_reg = 1'b1;
                o_ctl.dest_sel  = DEST_RD;
                o_ctl.alu_op    = ALU_FUNCT;
                if (i_funct == FUNCT_JR) begin
                    o_ctl.write_reg = 1'b0;
                    o_ctl.jump      = JMP_JR;
                end
            end
            OP_ADDI:  begin o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1; o_ctl.alu_op = ALU_ADD;  end
            OP_ADDIU: begin o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1; o_ctl.alu_op = ALU_ADDU; end
            OP_SLTI:  begin o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1; o_ctl.alu_op = ALU_SLT;  end
            OP_SLTIU: begin o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1; o_ctl.alu_op = ALU_SLTU; end
            OP_ANDI: begin
                o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1;
                o_ctl.alu_op = ALU_AND; o_ctl.imm_ext = IMM_ZERO;
            end
            OP_ORI: begin
                o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1;
                o_ctl.alu_op = ALU_OR; o_ctl.imm_ext = IMM_ZERO;
            end
            OP_XORI: begin
                o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1;
                o_ctl.alu_op = ALU_XOR; o_ctl.imm_ext = IMM_ZERO;
            end
            OP_LUI: begin
                o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1;
                o_ctl.alu_op = ALU_LUI; o_ctl.imm_ext = IMM_UPPER;
            end
            OP_LW: begin
                o_ctl.write_reg = 1'b1; o_ctl.alu_src_imm = 1'b1; o_ctl.alu_op = ALU_ADDU;
                o_ctl.mem_read = 1'b1; o_ctl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                o_ctl.alu_src_imm = 1'b1; o_ctl.alu_op = ALU_ADDU; o_ctl.mem_write = 1'b1;
            end
            OP_BEQ: begin o_ctl.alu_op = ALU_SUB; o_ctl.branch = BR_EQ; end
            OP_BNE: begin o_ctl.alu_op = ALU_SUB; o_ctl.branch = BR_NE; end
            OP_J:   o_ctl.jump = JMP_J;
            OP_JAL: begin
                o_ctl.jump = JMP_J; o_ctl.link = 1'b1;
                o_ctl.write_reg = 1'b1; o_ctl.dest_sel = DEST_R31;
            end
            default: o_ctl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_pipeline_unit_preg.sv
// Fetch/decode pipeline register: 1-cycle latency, nullify loads a bubble.
// stall holds contents; nullify overrides stall.
module decode_pipeline_unit_preg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall,
    input  logic             i_nullify,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_pcadd4,
    input  logic [WIDTH-1:0] i_instruction,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pcadd4,
    output logic [WIDTH-1:0] o_instruction
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pcadd4;
    logic [WIDTH-1:0] r_instruction;

    // An all-zero instruction word is sll $0,$0,0, so a bubble decodes as a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= '0;
            r_pcadd4      <= '0;
            r_instruction <= '0;
        end else if (i_nullify) begin
            r_pc          <= '0;
            r_pcadd4      <= '0;
            r_instruction <= '0;
        end else if (!i_stall) begin
            r_pc          <= i_pc;
            r_pcadd4      <= i_pcadd4;
            r_instruction <= i_instruction;
        end
    end

    assign o_pc          = r_pc;
    assign o_pcadd4      = r_pcadd4;
    assign o_instruction = r_instruction;
endmodule

// File: rtl/decode_pipeline_unit.sv
// MIPS decode-stage core: latches the fetch bundle (1 cycle) and decodes it combinationally.
// stall holds the latched instruction; nullify replaces it with a NOP bubble.
module decode_pipeline_unit
    import signals::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    decode_pipeline_unit_if.slave bus
);
    logic [WIDTH-1:0] w_instruction;

    decode_pipeline_unit_preg #(.WIDTH(WIDTH)) u_preg (
        .clk           (clk),
        .reset         (reset),
        .i_stall       (bus.stall),
        .i_nullify     (bus.nullify),
        .i_pc          (bus.in_pc),
        .i_pcadd4      (bus.in_pcadd4),
        .i_instruction (bus.in_instruction),
        .o_pc          (bus.out_pc),
        .o_pcadd4      (bus.out_pcadd4),
        .o_instruction (w_instruction)
    );

    assign bus.out_instruction = w_instruction;

    assign bus.unpack.opcode = w_instruction[31:26];
    assign bus.unpack.rs     = w_instruction[25:21];
    assign bus.unpack.rt     = w_instruction[20:16];
    assign bus.unpack.rd     = w_instruction[15:11];
    assign bus.unpack.shamt  = w_instruction[10:6];
    assign bus.unpack.funct  = w_instruction[5:0];
    assign bus.unpack.imm    = w_instruction[15:0];
    assign bus.unpack.jaddr  = w_instruction[25:0];

    opcode_decoder u_dec (
        .i_opcode (w_instruction[31:26]),
        .i_funct  (w_instruction[5:0]),
        .o_ctl    (bus.ctl)
    );
endmodule

// File: tb/tb_decode_pipeline_unit.sv
// Bench for decode_pipeline_unit: vector table through a scoreboard plus reset corner cases.
module tb_decode_pipeline_unit;
    import signals::*;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    decode_pipeline_unit_if bus ();

    decode_pipeline_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic        stall;
        logic        nullify;
        logic [31:0] instr;
        logic [31:0] exp_instr;
        control_t    exp_ctl;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcadd4;
        logic [31:0] instr;
        control_t    ctl;
    } exp_t;

    exp_t sb[$];

    function automatic control_t mk(input logic wr, input logic [1:0] dst, input logic src,
                                    input logic [1:0] ext, input logic [3:0] op,
                                    input logic mr, input logic mw, input logic m2r,
                                    input logic [1:0] br, input logic [1:0] jmp,
                                    input logic lnk, input logic ill);
        control_t c;
        c = {wr, dst, src, ext, op, mr, mw, m2r, br, jmp, lnk, ill};
        return c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_unpack(input string name, input logic [31:0] w);
        unpack_t u;
        u.opcode = w[31:26]; u.rs = w[25:21]; u.rt = w[20:16]; u.rd = w[15:11];
        u.shamt = w[10:6]; u.funct = w[5:0]; u.imm = w[15:0]; u.jaddr = w[25:0];
        chk(name, 128'(bus.unpack), 128'(u));
    endtask

    control_t c_nop, c_addi, c_sw, c_lw, c_bne, c_jal, c_jr, c_ill, c_ori, c_lui;
    control_t c_beq, c_j, c_andi, c_slti, c_sltiu, c_xori, c_addiu;
    vec_t vecs[20];
    logic [31:0] m_pc, m_pc4;

    initial begin
        //                wr dst src ext op   mr mw m2r br jmp lnk ill
        c_nop   = mk(1, 1, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0);
        c_addi  = mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        c_sw    = mk(0, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0);
        c_lw    = mk(1, 0, 1, 0, 1,  1, 0, 1, 0, 0, 0, 0);
        c_bne   = mk(0, 0, 0, 0, 2,  0, 0, 0, 2, 0, 0, 0);
        c_jal   = mk(1, 2, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0);
        c_jr    = mk(0, 1, 0, 0, 15, 0, 0, 0, 0, 2, 0, 0);
        c_ill   = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
        c_ori   = mk(1, 0, 1, 1, 4,  0, 0, 0, 0, 0, 0, 0);
        c_lui   = mk(1, 0, 1, 2, 9,  0, 0, 0, 0, 0, 0, 0);
        c_beq   = mk(0, 0, 0, 0, 2,  0, 0, 0, 1, 0, 0, 0);
        c_j     = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
        c_andi  = mk(1, 0, 1, 1, 3,  0, 0, 0, 0, 0, 0, 0);
        c_slti  = mk(1, 0, 1, 0, 7,  0, 0, 0, 0, 0, 0, 0);
        c_sltiu = mk(1, 0, 1, 0, 8,  0, 0, 0, 0, 0, 0, 0);
        c_xori  = mk(1, 0, 1, 1, 5,  0, 0, 0, 0, 0, 0, 0);
        c_addiu = mk(1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = '{1'b1, 1'b0, 32'hAC090004, 32'h20080005, c_addi};
        vecs[1]  = '{1'b1, 1'b0, 32'hAC090004, 32'h20080005, c_addi};
        vecs[2]  = '{1'b1, 1'b0, 32'hAC090004, 32'h20080005, c_addi};
        vecs[3]  = '{1'b0, 1'b0, 32'hAC090004, 32'hAC090004, c_sw};
        vecs[4]  = '{1'b1, 1'b1, 32'h8C0A0008, 32'h00000000, c_nop};
        vecs[5]  = '{1'b0, 1'b0, 32'h8C0A0008, 32'h8C0A0008, c_lw};
        vecs[6]  = '{1'b0, 1'b0, 32'h15090003, 32'h15090003, c_bne};
        vecs[7]  = '{1'b0, 1'b0, 32'h0C000010, 32'h0C000010, c_jal};
        vecs[8]  = '{1'b0, 1'b0, 32'h03E00008, 32'h03E00008, c_jr};
        vecs[9]  = '{1'b0, 1'b0, 32'hFC000000, 32'hFC000000, c_ill};
        vecs[10] = '{1'b0, 1'b0, 32'h3508FFFF, 32'h3508FFFF, c_ori};
        vecs[11] = '{1'b0, 1'b0, 32'h3C081234, 32'h3C081234, c_lui};
        vecs[12] = '{1'b0, 1'b0, 32'h11090002, 32'h11090002, c_beq};
        vecs[13] = '{1'b0, 1'b0, 32'h08000010, 32'h08000010, c_j};
        vecs[14] = '{1'b0, 1'b0, 32'h3108000F, 32'h3108000F, c_andi};
        vecs[15] = '{1'b0, 1'b0, 32'h29080001, 32'h29080001, c_slti};
        vecs[16] = '{1'b0, 1'b0, 32'h2D080001, 32'h2D080001, c_sltiu};
        vecs[17] = '{1'b0, 1'b0, 32'h39080001, 32'h39080001, c_xori};
        vecs[18] = '{1'b0, 1'b0, 32'h25080001, 32'h25080001, c_addiu};
        vecs[19] = '{1'b0, 1'b1, 32'h25080001, 32'h00000000, c_nop};

        // Reset state with live inputs present.
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.nullify = 1'b0;
        bus.in_pc = 32'h1234;
        bus.in_pcadd4 = 32'h1238;
        bus.in_instruction = 32'h20080005;
        #2 reset = 1'b0;
        #1;
        chk("rst_pc", 128'(bus.out_pc), 128'h0);
        chk("rst_pcadd4", 128'(bus.out_pcadd4), 128'h0);
        chk("rst_instr", 128'(bus.out_instruction), 128'h0);
        chk("rst_ctl", 128'(bus.ctl), 128'(c_nop));

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first_pc", 128'(bus.out_pc), 128'h1234);
        chk("first_pcadd4", 128'(bus.out_pcadd4), 128'h1238);
        chk("first_instr", 128'(bus.out_instruction), 128'h20080005);
        chk("addi_ctl", 128'(bus.ctl), 128'(c_addi));
        chk("addi_rs", 128'(bus.unpack.rs), 128'd0);
        chk("addi_rt", 128'(bus.unpack.rt), 128'd8);
        chk("addi_imm", 128'(bus.unpack.imm), 128'd5);
        m_pc = 32'h1234;
        m_pc4 = 32'h1238;

        for (int i = 0; i < 20; i++) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            bus.stall = vecs[i].stall;
            bus.nullify = vecs[i].nullify;
            bus.in_pc = 32'h2000 + 32'(i) * 4;
            bus.in_pcadd4 = 32'h2004 + 32'(i) * 4;
            bus.in_instruction = vecs[i].instr;
            if (vecs[i].nullify) begin
                m_pc = '0; m_pc4 = '0;
            end else if (!vecs[i].stall) begin
                m_pc = bus.in_pc; m_pc4 = bus.in_pcadd4;
            end
            e.pc = m_pc; e.pcadd4 = m_pc4; e.instr = vecs[i].exp_instr; e.ctl = vecs[i].exp_ctl;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("sb_empty[%0d]", i), 128'd0, 128'd1);
            end else begin
                got = sb.pop_front();
                chk($sformatf("pc[%0d]", i), 128'(bus.out_pc), 128'(got.pc));
                chk($sformatf("pcadd4[%0d]", i), 128'(bus.out_pcadd4), 128'(got.pcadd4));
                chk($sformatf("instr[%0d]", i), 128'(bus.out_instruction), 128'(got.instr));
                chk($sformatf("ctl[%0d]", i), 128'(bus.ctl), 128'(got.ctl));
                chk_unpack($sformatf("unpack[%0d]", i), got.instr);
            end
        end
        chk("sb_drained", 128'(sb.size()), 128'd0);

        // Asynchronous reset between edges, with stall held high.
        @(negedge clk);
        bus.stall = 1'b0;
        bus.nullify = 1'b0;
        bus.in_pc = 32'h3000;
        bus.in_pcadd4 = 32'h3004;
        bus.in_instruction = 32'h8C0A0008;
        @(posedge clk);
        #1;
        chk("pre_arst_instr", 128'(bus.out_instruction), 128'h8C0A0008);
        bus.stall = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("arst_pc", 128'(bus.out_pc), 128'h0);
        chk("arst_pcadd4", 128'(bus.out_pcadd4), 128'h0);
        chk("arst_instr", 128'(bus.out_instruction), 128'h0);
        chk("arst_ctl", 128'(bus.ctl), 128'(c_nop));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_arst_stall_instr", 128'(bus.out_instruction), 128'h0);
        @(negedge clk);
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        chk("post_arst_load_pc", 128'(bus.out_pc), 128'h3000);
        chk("post_arst_load_ctl", 128'(bus.ctl), 128'(c_lw));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_pipeline_unit.md
Name: decode_pipeline_unit

Overview:
- Decode-stage core of the 5-stage MIPS pipeline.
- Latches the fetch-stage bundle (pc, pcadd4, instruction) in a stall/nullify-capable pipeline register.
- Splits the latched instruction into its fields and decodes the main opcode into a control bundle.
- Register-file reads and writeback stay in the enclosing stage.

Parameters:
- WIDTH, 32, datapath/instruction width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold the pipeline register
- nullify  in  1  load a bubble (all zeros) instead of the inputs
- in_pc  in  32  fetch PC
- in_pcadd4  in  32  fetch PC+4
- in_instruction  in  32  fetched instruction word
- out_pc  out  32  latched PC
- out_pcadd4  out  32  latched PC+4
- out_instruction  out  32  latched instruction
- unpack  out  unpack_t (74)  fields of out_instruction
- ctl  out  control_t (19)  decoded control bundle

Behaviour:
- Single clock domain. Reset is asynchronous, active-low; the port is named reset.
- Reset (reset=0): out_pc, out_pcadd4, out_instruction = 0 immediately. The 0 word is NOP (sll $0,$0,0) and decodes as R-type with dest rd=0.
- Each rising edge with reset=1, priority order:
  - nullify=1: all three registers load 0. nullify wins over stall.
  - else stall=1: registers hold.
  - else: registers load in_*.
- Latency: 1 cycle from in_* to out_*. unpack and ctl are purely combinational from out_instruction (0 extra cycles).
- unpack fields:
  - opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0]
  - imm=[15:0], jaddr=[25:0]
- control_t fields and encodings:
  - write_reg 1
  - dest_sel 2: 0=rt, 1=rd, 2=r31
  - alu_src_imm 1
  - imm_ext 2: 0=sign, 1=zero, 2=upper (imm<<16)
  - alu_op 4: ADD0, ADDU1, SUB2, AND3, OR4, XOR5, NOR6, SLT7, SLTU8, LUI9, FUNCT15
  - mem_read 1, mem_write 1, mem_to_reg 1
  - branch 2: 0=none, 1=beq, 2=bne
  - jump 2: 0=none, 1=j, 2=jr
  - link 1, illegal 1
- Default for every field is 0. Opcode decode (only non-default fields listed):
  - 000000 SPECIAL: write_reg=1, dest_sel=rd, alu_op=FUNCT. If funct=001000 (JR): write_reg=0, jump=jr.
  - 001000 ADDI: write_reg, alu_src_imm, ADD (sign ext)
  - 001001 ADDIU: write_reg, alu_src_imm, ADDU (sign ext)
  - 001010 SLTI: write_reg, alu_src_imm, SLT (sign ext)
  - 001011 SLTIU: write_reg, alu_src_imm, SLTU (sign ext)
  - 001100 ANDI: write_reg, alu_src_imm, AND, imm_ext=zero
  - 001101 ORI: write_reg, alu_src_imm, OR, imm_ext=zero
  - 001110 XORI: write_reg, alu_src_imm, XOR, imm_ext=zero
  - 001111 LUI: write_reg, alu_src_imm, LUI, imm_ext=upper
  - 100011 LW: write_reg, alu_src_imm, ADDU, mem_read, mem_to_reg
  - 101011 SW: alu_src_imm, ADDU, mem_write
  - 000100 BEQ: SUB, branch=beq
  - 000101 BNE: SUB, branch=bne
  - 000010 J: jump=j
  - 000011 JAL: jump=j, link, write_reg, dest_sel=r31
  - any other opcode: all fields 0 except illegal=1
- stall and nullify together: nullify wins.
- Reset mid-stall: registers clear to 0 regardless of stall.

Decomposition:
- Package `signals`:
  - unpack_t, control_t (packed structs)
  - enums for dest_sel, imm_ext, alu_op, branch, jump
  - opcode constants (SPECIAL, ADDI, …, JAL) and FUNCT_JR
- Sub-modules:
  - the pipeline register (reset/stall/nullify logic)
  - a purely combinational opcode decoder, named opcode_decoder
  - field extraction done inline with continuous assigns

Test Plan:
- reset low with inputs 0x1234/0x1238/0x20080005 -> all outs 0; ctl = R-type, write_reg=1, dest_sel=rd. Release reset, one edge -> out_pc=0x1234, out_instruction=0x20080005.
- ADDI $t0,$0,5 (0x20080005) -> unpack rs=0, rt=8, imm=5; ctl write_reg=1, dest_sel=rt, alu_src_imm=1, alu_op=ADD, imm_ext=sign.
- stall=1 for 3 cycles while in_instruction changes to 0xAC090004 -> outputs hold 0x20080005. stall=0 -> SW decode: mem_write=1, write_reg=0.
- nullify=1 and stall=1 on same edge -> outs become 0 (NOP).
- Instruction sequence LW 0x8C0A0008, BNE 0x15090003, JAL 0x0C000010, JR 0x03E00008, opcode 111111 -> respectively:
  - LW: mem_read=1, mem_to_reg=1
  - BNE: branch=bne
  - JAL: link=1, dest_sel=r31, jump=j
  - JR: jump=jr, write_reg=0
  - opcode 111111: illegal=1, all else 0
- Async reset asserted mid-cycle (between edges) -> outputs clear without waiting for clk.
